multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: MultiCycleCtrl

---
 rtl/multi_cycle_ctrl_pkg.sv | 49 ++++
 rtl/multi_cycle_ctrl_decode.sv | 66 ++++++
 rtl/multi_cycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: FSM state
// encodings, opcode values, mux-select encodings and the reset IR value.
package multi_cycle_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned IMM_SEL_W = 3;
    localparam int unsigned PC_SEL_W  = 2;
    localparam int unsigned WB_SEL_W  = 2;
    localparam int unsigned REG_W     = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    localparam logic [IMM_SEL_W-1:0] IMM_I = 3'd0;
    localparam logic [IMM_SEL_W-1:0] IMM_S = 3'd1;
    localparam logic [IMM_SEL_W-1:0] IMM_B = 3'd2;
    localparam logic [IMM_SEL_W-1:0] IMM_U = 3'd3;
    localparam logic [IMM_SEL_W-1:0] IMM_J = 3'd4;

    localparam logic [PC_SEL_W-1:0] PC_PLUS4  = 2'd0;
    localparam logic [PC_SEL_W-1:0] PC_REL    = 2'd1;
    localparam logic [PC_SEL_W-1:0] PC_RS1IMM = 2'd2;

    localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd0;
    localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd1;
    localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'd2;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_IR_DEFAULT = 32'h00000013;

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational opcode decode for the multi-cycle controller.
// Ports:
//   opcode_i    - ir[6:0]
//   legal_o     - opcode is one of the nine supported base opcodes
//   is_branch_o, is_load_o, is_store_o, is_jal_o, is_jalr_o - class flags
//   imm_sel_o   - immediate format (I/S/B/U/J), I for anything unknown
module multi_cycle_ctrl_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0]     opcode_i,
    output logic                 legal_o,
    output logic                 is_branch_o,
    output logic                 is_load_o,
    output logic                 is_store_o,
    output logic                 is_jal_o,
    output logic                 is_jalr_o,
    output logic [IMM_SEL_W-1:0] imm_sel_o
);

    // Opcode classification and immediate format
    always_comb begin
        legal_o     = 1'b0;
        is_branch_o = 1'b0;
        is_load_o   = 1'b0;
        is_store_o  = 1'b0;
        is_jal_o    = 1'b0;
        is_jalr_o   = 1'b0;
        imm_sel_o   = IMM_I;
        case (opcode_i)
            OPC_LUI, OPC_AUIPC: begin
                legal_o   = 1'b1;
                imm_sel_o = IMM_U;
            end
            OPC_JAL: begin
                legal_o   = 1'b1;
                is_jal_o  = 1'b1;
                imm_sel_o = IMM_J;
            end
            OPC_JALR: begin
                legal_o   = 1'b1;
                is_jalr_o = 1'b1;
            end
            OPC_BRANCH: begin
                legal_o     = 1'b1;
                is_branch_o = 1'b1;
                imm_sel_o   = IMM_B;
            end
            OPC_LOAD: begin
                legal_o   = 1'b1;
                is_load_o = 1'b1;
            end
            OPC_STORE: begin
                legal_o    = 1'b1;
                is_store_o = 1'b1;
                imm_sel_o  = IMM_S;
            end
            OPC_OP_IMM, OPC_OP: begin
                legal_o = 1'b1;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I sequencing controller: FETCH -> DECODE -> EXEC ->
// (MEM) -> (WB) -> FETCH, with a sticky TRAP state for illegal opcodes.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   io_imem_req/ack, io_instr - instruction fetch handshake and data
//   io_dmem_req/wen/ack     - data access handshake (wen=1 store)
//   io_ir                   - latched instruction word
//   io_imm_sel              - immediate format for io_ir
//   io_br_taken             - branch comparator result (used in EXEC)
//   io_pc_wen, io_pc_sel    - PC update strobe and source
//   io_rf_wen, io_wb_sel    - register write strobe and source
//   io_illegal              - sticky illegal-opcode flag
//   io_state                - current state encoding
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_IR = RESET_IR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 io_imem_req,
    input  logic                 io_imem_ack,
    input  logic [XLEN-1:0]      io_instr,
    output logic                 io_dmem_req,
    output logic                 io_dmem_wen,
    input  logic                 io_dmem_ack,
    output logic [XLEN-1:0]      io_ir,
    output logic [IMM_SEL_W-1:0] io_imm_sel,
    input  logic                 io_br_taken,
    output logic                 io_pc_wen,
    output logic [PC_SEL_W-1:0]  io_pc_sel,
    output logic                 io_rf_wen,
    output logic [WB_SEL_W-1:0]  io_wb_sel,
    output logic                 io_illegal,
    output logic [STATE_W-1:0]   io_state
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic              illegal_q, illegal_d;

    logic              dec_legal, dec_branch, dec_load, dec_store, dec_jal, dec_jalr;
    logic              rd_nz;

    logic              imem_req_c, dmem_req_c, dmem_wen_c, pc_wen_c, rf_wen_c;
    logic [PC_SEL_W-1:0] pc_sel_c;
    logic [WB_SEL_W-1:0] wb_sel_c;

    multi_cycle_ctrl_decode u_decode (
        .opcode_i    (ir_q[OPC_W-1:0]),
        .legal_o     (dec_legal),
        .is_branch_o (dec_branch),
        .is_load_o   (dec_load),
        .is_store_o  (dec_store),
        .is_jal_o    (dec_jal),
        .is_jalr_o   (dec_jalr),
        .imm_sel_o   (io_imm_sel)
    );

    assign rd_nz = |ir_q[11:7];

    // State, instruction and sticky-flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= RESET_IR;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_wen_c = 1'b0;
        pc_wen_c   = 1'b0;
        pc_sel_c   = PC_PLUS4;
        rf_wen_c   = 1'b0;
        wb_sel_c   = WB_ALU;
        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (io_imem_ack) begin
                    ir_d    = io_instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (dec_branch) begin
                    pc_wen_c = 1'b1;
                    pc_sel_c = io_br_taken ? PC_REL : PC_PLUS4;
                    state_d  = ST_FETCH;
                end else if (dec_load || dec_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_wen_c = dec_store;
                if (io_dmem_ack) begin
                    if (dec_store) begin
                        pc_wen_c = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                pc_wen_c = 1'b1;
                pc_sel_c = dec_jal ? PC_REL : (dec_jalr ? PC_RS1IMM : PC_PLUS4);
                wb_sel_c = dec_load ? WB_MEM : ((dec_jal || dec_jalr) ? WB_PC4 : WB_ALU);
                rf_wen_c = rd_nz;
                state_d  = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Requests and strobes drop combinationally while reset is held
    assign io_imem_req = imem_req_c & ~reset;
    assign io_dmem_req = dmem_req_c & ~reset;
    assign io_dmem_wen = dmem_wen_c & ~reset;
    assign io_pc_wen   = pc_wen_c   & ~reset;
    assign io_rf_wen   = rf_wen_c   & ~reset;
    assign io_pc_sel   = pc_sel_c;
    assign io_wb_sel   = wb_sel_c;
    assign io_ir       = ir_q;
    assign io_illegal  = illegal_q;
    assign io_state    = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized self-checking bench for multi_cycle_ctrl with a
// transaction-level reference model of per-instruction behaviour.
module tb_multi_cycle_ctrl;

    localparam int BUDGET = 40;

    localparam int C_BR   = 0;
    localparam int C_LD   = 1;
    localparam int C_ST   = 2;
    localparam int C_JAL  = 3;
    localparam int C_JALR = 4;
    localparam int C_ALU  = 5;
    localparam int C_ILL  = 6;

    logic        clk;
    logic        reset;
    logic        io_imem_req;
    logic        io_imem_ack;
    logic [31:0] io_instr;
    logic        io_dmem_req;
    logic        io_dmem_wen;
    logic        io_dmem_ack;
    logic [31:0] io_ir;
    logic [2:0]  io_imm_sel;
    logic        io_br_taken;
    logic        io_pc_wen;
    logic [1:0]  io_pc_sel;
    logic        io_rf_wen;
    logic [1:0]  io_wb_sel;
    logic        io_illegal;
    logic [2:0]  io_state;

    int n_cmp = 0;
    int n_bad = 0;

    multi_cycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .io_imem_req (io_imem_req),
        .io_imem_ack (io_imem_ack),
        .io_instr    (io_instr),
        .io_dmem_req (io_dmem_req),
        .io_dmem_wen (io_dmem_wen),
        .io_dmem_ack (io_dmem_ack),
        .io_ir       (io_ir),
        .io_imm_sel  (io_imm_sel),
        .io_br_taken (io_br_taken),
        .io_pc_wen   (io_pc_wen),
        .io_pc_sel   (io_pc_sel),
        .io_rf_wen   (io_rf_wen),
        .io_wb_sel   (io_wb_sel),
        .io_illegal  (io_illegal),
        .io_state    (io_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [6:0] opc);
        case (opc)
            7'b1100011: return C_BR;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: return C_ALU;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int imm_of(input logic [6:0] opc);
        case (opc)
            7'b0100011:             return 1;
            7'b1100011:             return 2;
            7'b0110111, 7'b0010111: return 3;
            7'b1101111:             return 4;
            default:                return 0;
        endcase
    endfunction

    // One instruction from FETCH back to FETCH; bt_mode<0 randomizes br_taken
    task automatic run_instr(input logic [31:0] instr, input int wi, input int wd, input int bt_mode);
        int cls;
        int exp_states[$];
        int obs_states[$];
        int imem_n, dmem_n, dwen_n, pcw_n, rfw_n, pcw_at, pcsel, wbsel, bt_exec;
        int imm_seen, bad_seq, exp_pcsel, exp_rfw, exp_wbsel, nmin;
        logic [31:0] ir_seen, ir_last;
        bit left, done, mem, wb;
        logic [2:0] st;
        cls = cls_of(instr[6:0]);
        imem_n = 0; dmem_n = 0; dwen_n = 0; pcw_n = 0; rfw_n = 0;
        pcw_at = -1; pcsel = -1; wbsel = -1; bt_exec = 0; imm_seen = -1;
        ir_seen = '0; ir_last = '0; left = 0; done = 0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (cyc > 0) @(negedge clk);
            st = io_state;
            if (st != 3'd0) left = 1;
            else if (left) begin
                done = 1;
                break;
            end
            io_br_taken = (bt_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(bt_mode);
            if (cyc == wi + 2) bt_exec = int'(io_br_taken);
            if (io_imem_req) begin
                io_instr    = instr;
                io_imem_ack = (imem_n == wi);
            end else begin
                io_instr    = $urandom;
                io_imem_ack = 1'($urandom_range(0, 1));
            end
            if (io_dmem_req) io_dmem_ack = (dmem_n == wd);
            else             io_dmem_ack = 1'($urandom_range(0, 1));
            #1;
            obs_states.push_back(int'(io_state));
            if (io_imem_req) imem_n++;
            if (io_dmem_req) begin
                dmem_n++;
                if (io_dmem_wen) dwen_n++;
            end
            if (io_pc_wen) begin
                pcw_n++;
                pcw_at = cyc;
                pcsel  = int'(io_pc_sel);
            end
            if (io_rf_wen) begin
                rfw_n++;
                wbsel = int'(io_wb_sel);
            end
            if (cyc == wi + 1) begin
                imm_seen = int'(io_imm_sel);
                ir_seen  = io_ir;
            end
            ir_last = io_ir;
        end

        // Reference behaviour
        mem = (cls == C_LD) || (cls == C_ST);
        wb  = (cls != C_BR) && (cls != C_ST);
        for (int i = 0; i <= wi; i++) exp_states.push_back(0);
        exp_states.push_back(1);
        exp_states.push_back(2);
        if (mem) for (int i = 0; i <= wd; i++) exp_states.push_back(3);
        if (wb) exp_states.push_back(4);
        case (cls)
            C_BR:    exp_pcsel = bt_exec;
            C_JAL:   exp_pcsel = 1;
            C_JALR:  exp_pcsel = 2;
            default: exp_pcsel = 0;
        endcase
        exp_rfw = (wb && instr[11:7] != 5'd0) ? 1 : 0;
        exp_wbsel = (cls == C_LD) ? 1 : ((cls == C_JAL || cls == C_JALR) ? 2 : 0);

        bad_seq = 0;
        nmin = (obs_states.size() < exp_states.size()) ? obs_states.size() : exp_states.size();
        for (int i = 0; i < nmin; i++) if (obs_states[i] != exp_states[i]) bad_seq++;

        check_eq("completed", 32'(done), 32'd1);
        check_eq("cycles", 32'(obs_states.size()), 32'(exp_states.size()));
        check_eq("state_seq_errs", 32'(bad_seq), 32'd0);
        check_eq("imem_req_cycles", 32'(imem_n), 32'(wi + 1));
        check_eq("dmem_req_cycles", 32'(dmem_n), mem ? 32'(wd + 1) : 32'd0);
        check_eq("dmem_wen_cycles", 32'(dwen_n), (cls == C_ST) ? 32'(wd + 1) : 32'd0);
        check_eq("pc_wen_pulses", 32'(pcw_n), 32'd1);
        check_eq("pc_wen_cycle", 32'(pcw_at), 32'(exp_states.size() - 1));
        check_eq("pc_sel", 32'(pcsel), 32'(exp_pcsel));
        check_eq("rf_wen_pulses", 32'(rfw_n), 32'(exp_rfw));
        if (exp_rfw == 1) check_eq("wb_sel", 32'(wbsel), 32'(exp_wbsel));
        check_eq("imm_sel", 32'(imm_seen), 32'(imm_of(instr[6:0])));
        check_eq("ir_latched", ir_seen, instr);
        check_eq("ir_held", ir_last, instr);
        check_eq("illegal_low", 32'(io_illegal), 32'd0);
    endtask

    // sw with a stalled data port, stray imem ack in EXEC, reset pulsed in MEM
    task automatic reset_mid_mem();
        logic [31:0] instr;
        int n3;
        bit ok;
        logic [2:0] st;
        instr = 32'h00112023;
        n3 = 0;
        ok = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            st = io_state;
            io_dmem_ack = 1'b0;
            io_br_taken = 1'b0;
            if (st == 3'd2) begin
                io_imem_ack = 1'b1;
                io_instr    = 32'h0000007F;
            end else if (io_imem_req) begin
                io_imem_ack = 1'b1;
                io_instr    = instr;
            end else begin
                io_imem_ack = 1'b0;
            end
            if (st == 3'd3) n3++;
            if (n3 == 2) begin
                ok = 1;
                break;
            end
        end
        check_eq("sw_reached_mem", 32'(ok), 32'd1);
        check_eq("sw_ir_after_stray", io_ir, instr);
        check_eq("sw_dmem_req_in_mem", 32'(io_dmem_req), 32'd1);
        check_eq("sw_dmem_wen_in_mem", 32'(io_dmem_wen), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_dmem_req", 32'(io_dmem_req), 32'd0);
        check_eq("rst_imem_req", 32'(io_imem_req), 32'd0);
        check_eq("rst_state", 32'(io_state), 32'd0);
        check_eq("rst_ir", io_ir, 32'h00000013);
        check_eq("rst_illegal", 32'(io_illegal), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("post_rst_imem_req", 32'(io_imem_req), 32'd1);
        check_eq("post_rst_state", 32'(io_state), 32'd0);
        @(negedge clk);
    endtask

    // Illegal opcode reaches TRAP, stays inert, and only reset recovers
    task automatic trap_test();
        int strobes;
        io_instr    = 32'h0000007F;
        io_imem_ack = 1'b1;
        io_dmem_ack = 1'b0;
        #1;
        @(negedge clk);
        io_imem_ack = 1'b0;
        check_eq("trap_decode_state", 32'(io_state), 32'd1);
        @(negedge clk);
        check_eq("trap_state", 32'(io_state), 32'd5);
        check_eq("trap_illegal", 32'(io_illegal), 32'd1);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            io_imem_ack = 1'($urandom_range(0, 1));
            io_dmem_ack = 1'($urandom_range(0, 1));
            io_br_taken = 1'($urandom_range(0, 1));
            #1;
            strobes += int'(io_imem_req) + int'(io_dmem_req) + int'(io_pc_wen) + int'(io_rf_wen);
        end
        check_eq("trap_strobes", 32'(strobes), 32'd0);
        check_eq("trap_state_held", 32'(io_state), 32'd5);
        check_eq("trap_illegal_held", 32'(io_illegal), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("trap_rst_state", 32'(io_state), 32'd0);
        check_eq("trap_rst_illegal", 32'(io_illegal), 32'd0);
        check_eq("trap_rst_ir", io_ir, 32'h00000013);
        @(negedge clk);
        io_imem_ack = 1'b0;
        io_dmem_ack = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("trap_post_rst_req", 32'(io_imem_req), 32'd1);
        @(negedge clk);
    endtask

    task automatic random_runs(input int n);
        logic [6:0] legal_opc [9];
        logic [31:0] instr;
        legal_opc[0] = 7'b0110111; legal_opc[1] = 7'b0010111; legal_opc[2] = 7'b1101111;
        legal_opc[3] = 7'b1100111; legal_opc[4] = 7'b1100011; legal_opc[5] = 7'b0000011;
        legal_opc[6] = 7'b0100011; legal_opc[7] = 7'b0010011; legal_opc[8] = 7'b0110011;
        for (int k = 0; k < n; k++) begin
            instr = $urandom;
            instr[6:0] = legal_opc[$urandom_range(0, 8)];
            if ($urandom_range(0, 3) == 0) instr[11:7] = 5'd0;
            run_instr(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
        end
    endtask

    initial begin
        reset       = 1'b1;
        io_imem_ack = 1'b0;
        io_dmem_ack = 1'b0;
        io_instr    = '0;
        io_br_taken = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("init_state", 32'(io_state), 32'd0);
        check_eq("init_ir", io_ir, 32'h00000013);
        check_eq("init_illegal", 32'(io_illegal), 32'd0);
        check_eq("init_imem_req_in_reset", 32'(io_imem_req), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("init_imem_req_after", 32'(io_imem_req), 32'd1);
        @(negedge clk);

        run_instr(32'h00500093, 0, 0, -1);
        run_instr(32'h00000463, 0, 0, 1);
        run_instr(32'h00000463, 0, 0, 0);
        run_instr(32'h00002103, 0, 3, -1);
        run_instr(32'h00112023, 0, 0, -1);
        run_instr(32'h008000EF, 0, 0, -1);
        run_instr(32'h00008067, 2, 0, -1);
        random_runs(60);
        reset_mid_mem();
        random_runs(20);
        trap_test();
        random_runs(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
